// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  localparam int WAIT_CNT_W = 16;

  function automatic logic srcHit(
    input logic                 uses,
    input logic [REG_IDX_W-1:0] rs,
    input logic [REG_IDX_W-1:0] rd
  );
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_dmem_handshake_fsm.sv
// Data-memory req/ready handshake with wait counting and forced release.
module dmem_handshake_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic memAccess,
  input  logic dmemReady,
  output logic dmemReq,
  output logic memStall,
  output logic forceBubble,
  output logic memTimeout
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT =
    WAIT_CNT_W'(TIMEOUT);

  mem_state_t            state;
  logic [WAIT_CNT_W-1:0] waitCnt;
  logic                  atLimit;

  assign atLimit = (waitCnt == LIMIT);

  always_comb begin
    dmemReq     = 1'b0;
    memStall    = 1'b0;
    forceBubble = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          dmemReq  = memAccess;
          memStall = memAccess && !dmemReady;
        end
        WAIT: begin
          dmemReq = 1'b1;
          if (!dmemReady) begin
            forceBubble = atLimit;
            memStall    = !atLimit;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memAccess && !dmemReady) begin
            state   <= WAIT;
            waitCnt <= WAIT_CNT_W'(1);
          end
        end
        WAIT: begin
          if (dmemReady) begin
            state   <= IDLE;
            waitCnt <= '0;
          end else if (atLimit) begin
            // give up: release the pipeline, MEM/WB gets a bubble
            state      <= IDLE;
            waitCnt    <= '0;
            memTimeout <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline registers.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT     = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_IDX_W-1:0]   ex_rd,
  input  logic                   ex_memRead,
  input  logic                   ex_branchTaken,
  input  logic                   mem_memRead,
  input  logic                   mem_memWrite,
  output logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   ifid_flush,
  output logic                   idex_en,
  output logic                   idex_flush,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   memwb_bubble,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic memAccess;
  logic memStall;
  logic forceBubble;
  logic loadUse;
  logic selStall;
  logic selBranch;
  logic selLoadUse;

  assign memAccess = mem_memRead | mem_memWrite;

  dmem_handshake_fsm #(
    .TIMEOUT(TIMEOUT)
  ) uHandshake (
    .clk        (clk),
    .reset      (reset),
    .memAccess  (memAccess),
    .dmemReady  (dmem_ready),
    .dmemReq    (dmem_req),
    .memStall   (memStall),
    .forceBubble(forceBubble),
    .memTimeout (mem_timeout)
  );

  assign loadUse = ex_memRead
    && (ex_rd != REG_X0)
    && (srcHit(id_uses_rs1, id_rs1, ex_rd)
     || srcHit(id_uses_rs2, id_rs2, ex_rd));

  assign selStall   = memStall;
  assign selBranch  = !memStall && ex_branchTaken;
  assign selLoadUse = !memStall && !ex_branchTaken
                   && loadUse;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (!reset) begin
      memwb_bubble = forceBubble;
      unique case (1'b1)
        selStall: begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_en     = 1'b0;
          memwb_bubble = 1'b1;
        end
        selBranch: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        selLoadUse: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_en && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random checks of pipeline_hazard_ctrl against a cycle model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    idRs1, idRs2, exRd;
  logic          useRs1, useRs2;
  logic          exMemRead, exBranch;
  logic          memRead, memWrite;
  logic          dmemReady;
  logic          dmemReq;
  logic          pcEn, ifidEn, ifidFlush;
  logic          idexEn, idexFlush;
  logic          exmemEn, memwbEn, memwbBubble;
  logic          memTimeout;
  logic [SW-1:0] stallCycles;

  int checks = 0;
  int errors = 0;

  // model: access age in cycles since its first MEM cycle
  bit              mOut;
  int              mAge;
  bit              mTo;
  longint unsigned mStalls;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .TIMEOUT    (TO),
    .STALL_CNT_W(SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (idRs1),
    .id_rs2        (idRs2),
    .id_uses_rs1   (useRs1),
    .id_uses_rs2   (useRs2),
    .ex_rd         (exRd),
    .ex_memRead    (exMemRead),
    .ex_branchTaken(exBranch),
    .mem_memRead   (memRead),
    .mem_memWrite  (memWrite),
    .dmem_req      (dmemReq),
    .dmem_ready    (dmemReady),
    .pc_en         (pcEn),
    .ifid_en       (ifidEn),
    .ifid_flush    (ifidFlush),
    .idex_en       (idexEn),
    .idex_flush    (idexFlush),
    .exmem_en      (exmemEn),
    .memwb_en      (memwbEn),
    .memwb_bubble  (memwbBubble),
    .mem_timeout   (memTimeout),
    .stall_cycles  (stallCycles)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset     = 1'b0;
    idRs1     = '0;
    idRs2     = '0;
    exRd      = '0;
    useRs1    = 1'b0;
    useRs2    = 1'b0;
    exMemRead = 1'b0;
    exBranch  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    dmemReady = 1'b0;
  endtask

  // check one cycle against the model, then advance a clock
  task automatic tick();
    bit act, stl, frc, lu;
    bit ePc, eIfE, eIfF, eIdE, eIdF;
    bit eExE, eWbE, eWbB, eReq;
    #1;
    act = mOut || memRead || memWrite;
    lu  = exMemRead && exRd != 0
       && ((useRs1 && idRs1 == exRd)
        || (useRs2 && idRs2 == exRd));
    stl = !reset && act && !dmemReady && mAge < TO;
    frc = !reset && act && !dmemReady && mAge >= TO;
    eReq = !reset && act;
    ePc = 1; eIfE = 1; eIfF = 0; eIdE = 1;
    eIdF = 0; eExE = 1; eWbE = 1; eWbB = frc;
    if (reset) begin
      eWbB = 0;
    end else if (stl) begin
      ePc = 0; eIfE = 0; eIdE = 0; eExE = 0;
      eWbB = 1;
    end else if (exBranch) begin
      eIfF = 1; eIdF = 1;
    end else if (lu) begin
      ePc = 0; eIfE = 0; eIdF = 1;
    end
    check("dmem_req", 64'(dmemReq), 64'(eReq));
    check("pc_en", 64'(pcEn), 64'(ePc));
    check("ifid_en", 64'(ifidEn), 64'(eIfE));
    check("ifid_flush", 64'(ifidFlush), 64'(eIfF));
    check("idex_en", 64'(idexEn), 64'(eIdE));
    check("idex_flush", 64'(idexFlush), 64'(eIdF));
    check("exmem_en", 64'(exmemEn), 64'(eExE));
    check("memwb_en", 64'(memwbEn), 64'(eWbE));
    check("memwb_bubble", 64'(memwbBubble), 64'(eWbB));
    check("mem_timeout", 64'(memTimeout), 64'(mTo));
    check("stall_cycles", 64'(stallCycles), mStalls);
    if (reset) begin
      mOut = 0; mAge = 0; mTo = 0; mStalls = 0;
    end else begin
      if (stl) begin
        mOut = 1; mAge++;
      end else begin
        mOut = 0; mAge = 0;
      end
      if (frc) mTo = 1;
      if (!ePc && mStalls < 64'hFFFF_FFFF) mStalls++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    longint unsigned base;
    mOut = 0; mAge = 0; mTo = 0; mStalls = 0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_stall_cnt", 64'(stallCycles), 64'd0);

    // load-use on rs1
    exMemRead = 1; exRd = 5; idRs1 = 5; useRs1 = 1;
    #1;
    check("lu_pc_en", 64'(pcEn), 64'd0);
    check("lu_idex_flush", 64'(idexFlush), 64'd1);
    tick();
    check("lu_stall_cnt", 64'(stallCycles), 64'd1);
    idle();
    tick();

    // x0 destination, then unused rs2 operand
    exMemRead = 1; exRd = 0; idRs1 = 0; useRs1 = 1;
    #1;
    check("x0_pc_en", 64'(pcEn), 64'd1);
    tick();
    idle();
    exMemRead = 1; exRd = 7; idRs2 = 7; useRs2 = 0;
    #1;
    check("unused_pc_en", 64'(pcEn), 64'd1);
    tick();

    // taken branch beats load-use
    idle();
    exMemRead = 1; exRd = 9; idRs2 = 9; useRs2 = 1;
    exBranch = 1;
    #1;
    check("br_pc_en", 64'(pcEn), 64'd1);
    check("br_ifid_flush", 64'(ifidFlush), 64'd1);
    tick();
    check("br_stall_cnt", 64'(stallCycles), 64'd1);

    // three-wait load
    idle();
    reset = 1;
    tick();
    idle();
    memRead = 1;
    for (int i = 0; i < 3; i++) tick();
    dmemReady = 1;
    #1;
    check("w3_req_4th", 64'(dmemReq), 64'd1);
    check("w3_exmem_en", 64'(exmemEn), 64'd1);
    tick();
    check("w3_stall_cnt", 64'(stallCycles), 64'd3);
    idle();
    #1;
    check("w3_idle_req", 64'(dmemReq), 64'd0);
    tick();

    // timeout with ready stuck low
    memWrite = 1;
    base = mStalls;
    for (int i = 0; i < TO; i++) tick();
    #1;
    check("to_release_pc", 64'(pcEn), 64'd1);
    check("to_bubble", 64'(memwbBubble), 64'd1);
    tick();
    check("to_flag", 64'(memTimeout), 64'd1);
    check("to_stalls", 64'(stallCycles), base + TO);
    idle();
    tick();
    tick();
    check("to_sticky", 64'(memTimeout), 64'd1);

    // reset on the second wait cycle
    memRead = 1;
    tick();
    tick();
    reset = 1;
    tick();
    idle();
    #1;
    check("rw_req", 64'(dmemReq), 64'd0);
    check("rw_stalls", 64'(stallCycles), 64'd0);
    check("rw_timeout", 64'(memTimeout), 64'd0);
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      idRs1     = 5'($urandom_range(0, 3));
      idRs2     = 5'($urandom_range(0, 3));
      exRd      = 5'($urandom_range(0, 3));
      useRs1    = 1'($urandom);
      useRs2    = 1'($urandom);
      exMemRead = ($urandom_range(0, 2) == 0);
      exBranch  = ($urandom_range(0, 4) == 0);
      memRead   = ($urandom_range(0, 3) == 0);
      memWrite  = ($urandom_range(0, 7) == 0);
      dmemReady = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
